// File: rtl/antilog_16_if.sv
// Valid/ready bus for antilog_16: log-domain (intgr, fraction) input pair and
// the reconstructed magnitude output.
interface antilog_16_if #(
    parameter int DW = 16,
    parameter int FW = 12,
    parameter int IW = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_nz;
    logic signed [IW-1:0] intgr;
    logic [FW-1:0]        fraction;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        data;
    logic                 out_ovf;

    modport master (
        output in_valid, in_nz, intgr, fraction, out_ready,
        input  in_ready, out_valid, data, out_ovf
    );

    modport slave (
        input  in_valid, in_nz, intgr, fraction, out_ready,
        output in_ready, out_valid, data, out_ovf
    );
endinterface

// File: rtl/antilog_16.sv
// Mitchell antilog: data = (2^FW + fraction) * 2^intgr, two-stage valid/ready pipeline.
// Define ANTILOG_SAT_EN to saturate overflowing results to all-ones and flag out_ovf.
module antilog_16 #(
    parameter int DW = 16,
    parameter int FW = 12,
    parameter int IW = 5
) (
    input logic         clk,
    input logic         rst_n,
    antilog_16_if.slave bus_if
);

    localparam logic signed [IW-1:0] OVF_LIM = IW'(3);
    localparam logic signed [IW-1:0] UNF_LIM = IW'(-13);
`ifdef ANTILOG_SAT_EN
    localparam int SW = FW + 1 + DW;
`else
    localparam int SW = DW;
`endif

    logic                 adv1;
    logic                 adv2;
    logic                 v1_q;
    logic                 v2_q;
    logic [FW:0]          mant1_q;
    logic signed [IW-1:0] intgr1_q;
    logic                 zero1_q;
    logic [DW-1:0]        data_q;
    logic [DW-1:0]        data_d;
    logic [SW-1:0]        ext;
    logic [SW-1:0]        shifted;
    logic [IW-1:0]        neg_amt;

    // A stage may take new content when it is empty or its content moves on this edge.
    assign adv2            = !v2_q || bus_if.out_ready;
    assign adv1            = !v1_q || adv2;
    assign bus_if.in_ready = adv1;
    assign bus_if.out_valid = v2_q;
    assign bus_if.data     = data_q;

    // NOTE: registers are written with non-blocking assignments so every stage
    // samples the previous-cycle value of the stage before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            mant1_q  <= '0;
            intgr1_q <= '0;
            zero1_q  <= 1'b0;
        end else if (adv1) begin
            v1_q <= bus_if.in_valid;
            if (bus_if.in_valid) begin
                mant1_q  <= {1'b1, bus_if.fraction};
                intgr1_q <= bus_if.intgr;
                zero1_q  <= !bus_if.in_nz || (bus_if.intgr < UNF_LIM);
            end
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ext     = SW'(mant1_q);
        neg_amt = -intgr1_q;
        shifted = intgr1_q[IW-1] ? (ext >> neg_amt) : (ext << $unsigned(intgr1_q));
    end

`ifdef ANTILOG_SAT_EN
    logic ovf1_q;
    logic ovf_q;
    logic ovf_d;
    logic sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf1_q <= 1'b0;
        end else if (adv1 && bus_if.in_valid) begin
            ovf1_q <= bus_if.intgr > OVF_LIM;
        end
    end

    always_comb begin
        sat    = ovf1_q || (|shifted[SW-1:DW]);
        data_d = shifted[DW-1:0];
        ovf_d  = 1'b0;
        if (zero1_q) begin
            data_d = '0;
        end else if (sat) begin
            data_d = '1;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv2 && v1_q) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus_if.out_ovf = ovf_q;
`else
    always_comb begin
        data_d = zero1_q ? '0 : shifted[DW-1:0];
    end

    assign bus_if.out_ovf = 1'b0;
`endif

    // NOTE: data is visible at the port and must read 0 out of reset, so the
    // output payload register is reset along with the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            data_q <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                data_q <= data_d;
            end
        end
    end

endmodule
